// File: rtl/axis_pack_ratio.sv
// axis_pack_ratio: S_BYTES-to-M_BYTES AXI4-Stream down-converter with run-time endian select.
// Define PACK_LEN_CHECK_EN to enforce FRAME_BEATS per frame with err_short/err_long reporting.
module axis_pack_ratio #(
    parameter int S_BYTES     = 2,
    parameter int M_BYTES     = 1,
    parameter int FRAME_BEATS = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_big_endian,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*S_BYTES-1:0] s_data,
    input  logic                 s_last,
    input  logic                 s_user,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [8*M_BYTES-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 err_short,
    output logic                 err_long
);
    localparam int RATIO = S_BYTES / M_BYTES;
    localparam int MW = 8 * M_BYTES;
    localparam int SW = 8 * S_BYTES;
    localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t state;
    logic [SW-1:0] hold;
    logic [IW-1:0] slice_idx;
    logic big_q, word_last;
    logic hs, fin, stop, step, start, load, at_max, next_max;

    function automatic logic [MW-1:0] pick(input logic [SW-1:0] w, input logic [IW-1:0] k, input logic big);
        logic [IW-1:0] idx;
        idx = big ? LAST_IDX - k : k;
        return w[MW*idx +: MW];
    endfunction

`ifdef PACK_LEN_CHECK_EN
    localparam int BW = $clog2(FRAME_BEATS + 1);
    localparam bit CHK = 1'b1;
    // beat_cnt tracks the frame index of the beat currently presented
    logic [BW-1:0] beat_cnt;
    always_ff @(posedge clk)
        if (rst || start) beat_cnt <= '0;
        else if (step || load) beat_cnt <= beat_cnt + 1'b1;
    assign at_max   = beat_cnt == BW'(FRAME_BEATS - 1);
    assign next_max = beat_cnt == BW'(FRAME_BEATS - 2);
`else
    localparam bit CHK = 1'b0;
    assign at_max   = 1'b0;
    assign next_max = 1'b0;
`endif
    localparam bit FIRST_MAX = CHK && FRAME_BEATS == 1;

    assign hs    = m_axis_tvalid && m_axis_tready;
    assign fin   = word_last && slice_idx == LAST_IDX;
    assign stop  = hs && m_axis_tlast;
    assign step  = hs && !m_axis_tlast && slice_idx != LAST_IDX;
    assign start = state == IDLE && s_valid && s_user;
    assign load  = state == ACTIVE && s_valid && s_ready;
    // a new word is taken when the output is empty or its final slice leaves this cycle
    assign s_ready = rst ? 1'b0 : state != ACTIVE ? 1'b1 :
                     !m_axis_tvalid || (slice_idx == LAST_IDX && m_axis_tready && !m_axis_tlast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold          <= '0;
            slice_idx     <= '0;
            big_q         <= 1'b0;
            word_last     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state         <= ACTIVE;
                    hold          <= s_data;
                    word_last     <= s_last;
                    big_q         <= cfg_big_endian;
                    slice_idx     <= '0;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= pick(s_data, IW'(0), cfg_big_endian);
                    m_axis_tuser  <= 1'b1;
                    m_axis_tlast  <= (LAST_IDX == IW'(0) && s_last) || FIRST_MAX;
                end
                ACTIVE: if (stop) begin
                    state         <= at_max && !fin ? DRAIN : IDLE;
                    err_short     <= CHK && fin && !at_max;
                    err_long      <= at_max && !fin;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tuser  <= 1'b0;
                end else if (step) begin
                    slice_idx    <= slice_idx + 1'b1;
                    m_axis_tdata <= pick(hold, slice_idx + 1'b1, big_q);
                    m_axis_tuser <= 1'b0;
                    m_axis_tlast <= (word_last && slice_idx + 1'b1 == LAST_IDX) || next_max;
                end else if (load) begin
                    hold          <= s_data;
                    word_last     <= s_last;
                    slice_idx     <= '0;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= pick(s_data, IW'(0), big_q);
                    m_axis_tuser  <= 1'b0;
                    m_axis_tlast  <= (LAST_IDX == IW'(0) && s_last) || next_max;
                end else if (hs) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tuser  <= 1'b0;
                end
                DRAIN: if (s_valid && s_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
